// File: rtl/cpu_stat_pkg.sv
// Shared types, syscall codes and counter increment for the CPU run-control/statistics stage.
// Counter behaviour at all-ones is selected by CPU_STAT_SATURATE_EN (saturate) or wraps when undefined.
package cpu_stat_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] SYS_PRINT_HEX = 32'd34;
    localparam logic [31:0] SYS_PAUSE     = 32'd50;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_CYC_W = 32;
    localparam int MAX_W     = 64;

    // Increment a counter of width w (held in the low bits of a MAX_W vector).
    function automatic logic [MAX_W-1:0] cnt_inc(input logic [MAX_W-1:0] val, input int w);
        logic [MAX_W-1:0] all_ones;
        if (w >= MAX_W)
            all_ones = '1;
        else
            all_ones = (MAX_W'(1) << w) - MAX_W'(1);
`ifdef CPU_STAT_SATURATE_EN
        if ((val & all_ones) == all_ones)
            return all_ones;
`endif
        return (val + MAX_W'(1)) & all_ones;
    endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// Purpose: synchronise a raw button level and flag its 0->1 transitions.
// Latency: rise is high in the cycle after the second sync flop captures the 1 (acts on the 3rd edge).
// Backpressure: none; one pulse per synchronised rising edge.
module btn_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/cpu_stat_ctrl.sv
// Purpose: run/pause/halt gate for the MIPS core plus retire statistics and syscall print latch.
// Latency: counters/syscall_out visible one cycle after retire; resume takes 3 edges from button rise.
// Backpressure: run_en low stalls the core; retires are ignored while stalled. Macro: CPU_STAT_SATURATE_EN.
module cpu_stat_ctrl
    import cpu_stat_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             resume,
    output logic             run_en,
    output logic             halted,
    output logic [CYC_W-1:0] total_cycle,
    output logic [CNT_W-1:0] unconditional,
    output logic [CNT_W-1:0] conditional,
    output logic [CNT_W-1:0] conditionalsucces,
    output logic [31:0]      syscall_out
);

    state_t state;
    state_t state_nxt;
    logic   retire;
    logic   resume_rise;

    btn_rise_detect u_resume (
        .clk  (clk),
        .rst  (rst),
        .btn  (resume),
        .rise (resume_rise)
    );

    assign retire = step & run_en;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (retire && syscall) begin
                    if (v0 == SYS_EXIT)
                        state_nxt = HALT;
                    else if (v0 == SYS_PAUSE)
                        state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (resume_rise)
                    state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    assign run_en = (state == RUN);
    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst)
            total_cycle <= '0;
        else if (retire)
            total_cycle <= CYC_W'(cnt_inc(MAX_W'(total_cycle), CYC_W));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            unconditional <= '0;
        else if (retire && is_jump)
            unconditional <= CNT_W'(cnt_inc(MAX_W'(unconditional), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            conditional <= '0;
        else if (retire && is_branch)
            conditional <= CNT_W'(cnt_inc(MAX_W'(conditional), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            conditionalsucces <= '0;
        else if (retire && is_branch && branch_taken)
            conditionalsucces <= CNT_W'(cnt_inc(MAX_W'(conditionalsucces), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            syscall_out <= 32'h0000_0000;
        else if (retire && syscall && (v0 == SYS_PRINT_HEX))
            syscall_out <= a0;
    end

endmodule

// File: tb/tb_cpu_stat_ctrl.sv
// Directed bench for cpu_stat_ctrl: vector table for retire counting, hand sequences for pause/halt/wrap/reset.
module tb_cpu_stat_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        is_jump;
    logic        is_branch;
    logic        branch_taken;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        resume;
    logic        run_en;
    logic        halted;
    logic [31:0] total_cycle;
    logic [15:0] unconditional;
    logic [15:0] conditional;
    logic [15:0] conditionalsucces;
    logic [31:0] syscall_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_stat_ctrl #(.CNT_W(16), .CYC_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .step              (step),
        .is_jump           (is_jump),
        .is_branch         (is_branch),
        .branch_taken      (branch_taken),
        .syscall           (syscall),
        .v0                (v0),
        .a0                (a0),
        .resume            (resume),
        .run_en            (run_en),
        .halted            (halted),
        .total_cycle       (total_cycle),
        .unconditional     (unconditional),
        .conditional       (conditional),
        .conditionalsucces (conditionalsucces),
        .syscall_out       (syscall_out)
    );

    typedef struct {
        logic        step;
        logic        jmp;
        logic        br;
        logic        tk;
        logic        sc;
        logic [31:0] v0;
        logic [31:0] a0;
        logic [31:0] e_tc;
        logic [15:0] e_un;
        logic [15:0] e_co;
        logic [15:0] e_su;
        logic        e_run;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        step = 0; is_jump = 0; is_branch = 0; branch_taken = 0;
        syscall = 0; v0 = '0; a0 = '0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] tc, input logic [15:0] un,
                             input logic [15:0] co, input logic [15:0] su,
                             input logic run, input logic hlt, input logic [31:0] out);
        check({tag, ".total_cycle"}, 64'(total_cycle), 64'(tc));
        check({tag, ".unconditional"}, 64'(unconditional), 64'(un));
        check({tag, ".conditional"}, 64'(conditional), 64'(co));
        check({tag, ".conditionalsucces"}, 64'(conditionalsucces), 64'(su));
        check({tag, ".run_en"}, 64'(run_en), 64'(run));
        check({tag, ".halted"}, 64'(halted), 64'(hlt));
        check({tag, ".syscall_out"}, 64'(syscall_out), 64'(out));
    endtask

    initial begin
        //            step jmp br tk sc  v0     a0            tc  un co su run out
        vecs[0] = '{1, 0, 1, 1, 0, 32'd0,  32'h0,        1, 0, 1, 1, 1, 32'h0};
        vecs[1] = '{1, 0, 1, 0, 0, 32'd0,  32'h0,        2, 0, 2, 1, 1, 32'h0};
        vecs[2] = '{1, 0, 1, 1, 0, 32'd0,  32'h0,        3, 0, 3, 2, 1, 32'h0};
        vecs[3] = '{1, 0, 1, 1, 0, 32'd0,  32'h0,        4, 0, 4, 3, 1, 32'h0};
        vecs[4] = '{1, 0, 1, 0, 0, 32'd0,  32'h0,        5, 0, 5, 3, 1, 32'h0};
        vecs[5] = '{1, 1, 0, 0, 0, 32'd0,  32'h0,        6, 1, 5, 3, 1, 32'h0};
        vecs[6] = '{0, 1, 1, 1, 0, 32'd0,  32'h0,        6, 1, 5, 3, 1, 32'h0};
        vecs[7] = '{1, 0, 0, 0, 1, 32'd34, 32'hDEADBEEF, 7, 1, 5, 3, 1, 32'hDEADBEEF};
        vecs[8] = '{1, 0, 0, 0, 1, 32'd7,  32'h12345678, 8, 1, 5, 3, 1, 32'hDEADBEEF};
        vecs[9] = '{1, 0, 0, 1, 0, 32'd0,  32'h0,        9, 1, 5, 3, 1, 32'hDEADBEEF};

        idle();
        resume = 0;
        rst = 0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 1, 0, 32'h0);
        rst = 1;

        for (int i = 0; i < 10; i++) begin
            step = vecs[i].step; is_jump = vecs[i].jmp; is_branch = vecs[i].br;
            branch_taken = vecs[i].tk; syscall = vecs[i].sc; v0 = vecs[i].v0; a0 = vecs[i].a0;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_tc, vecs[i].e_un, vecs[i].e_co,
                      vecs[i].e_su, vecs[i].e_run, 1'b0, vecs[i].e_out);
        end

        // Pause with resume already held high: no resume until a fresh rise.
        idle();
        resume = 1;
        repeat (4) tick();
        check("run_resume_ignored", 64'(run_en), 64'd1);
        step = 1; syscall = 1; v0 = 32'd50;
        tick();
        check_all("pause_entry", 10, 1, 5, 3, 0, 0, 32'hDEADBEEF);
        syscall = 0; v0 = '0; is_jump = 1; is_branch = 1; branch_taken = 1;
        repeat (6) tick();
        check_all("pause_frozen", 10, 1, 5, 3, 0, 0, 32'hDEADBEEF);
        idle();
        resume = 0;
        repeat (3) tick();
        check("pause_after_drop", 64'(run_en), 64'd0);
        resume = 1;
        tick();
        check("resume_edge1", 64'(run_en), 64'd0);
        tick();
        check("resume_edge2", 64'(run_en), 64'd0);
        tick();
        check("resume_edge3", 64'(run_en), 64'd1);
        check("resume_tc", 64'(total_cycle), 64'd10);

        // Halt, resume pulse ignored, reset recovers.
        step = 1; syscall = 1; v0 = 32'd10;
        tick();
        check_all("halt_entry", 11, 1, 5, 3, 0, 1, 32'hDEADBEEF);
        idle();
        step = 1; is_jump = 1;
        resume = 0;
        repeat (3) tick();
        resume = 1;
        repeat (5) tick();
        check_all("halt_hold", 11, 1, 5, 3, 0, 1, 32'hDEADBEEF);
        idle();
        resume = 0;
        rst = 0;
        tick();
        rst = 1;
        check_all("halt_reset", 0, 0, 0, 0, 1, 0, 32'h0);

        // Jump counter boundary at all-ones.
        step = 1; is_jump = 1;
        repeat (65535) @(posedge clk);
        #1;
        check("jump_preload", 64'(unconditional), 64'hFFFF);
        tick();
`ifdef CPU_STAT_SATURATE_EN
        check("jump_boundary", 64'(unconditional), 64'hFFFF);
`else
        check("jump_boundary", 64'(unconditional), 64'h0000);
`endif
        check("jump_boundary_tc", 64'(total_cycle), 64'd65536);

        // Reset coinciding with a halting syscall wins.
        idle();
        step = 1; syscall = 1; v0 = 32'd10;
        rst = 0;
        tick();
        check_all("rst_vs_exit", 0, 0, 0, 0, 1, 0, 32'h0);
        rst = 1;
        idle();
        tick();
        check_all("rst_vs_exit_after", 0, 0, 0, 0, 1, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
